apb_event_unit_v2: RTL and testbench

Parametrised successor of the APB event/interrupt unit. It adds the following over the previous block:
- configurable line count and trigger mode (level or rising edge);
- write-1-to-set and write-1-to-clear pending registers;
- a separate event pending path;
- a sleep FSM that gates core fetch until an enabled event or interrupt wakes the core.

It sits on the peripheral APB bus beside the core. It drives the core's irq and fetch-enable inputs.

---
 rtl/apb_event_unit_v2_if.sv | 13 +
 rtl/apb_event_unit_v2.sv | 107 ++++++++++
 tb/tb_apb_event_unit_v2.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/apb_event_unit_v2_if.sv
// apb_event_unit_v2_if: APB slave bus bundle for the event unit
interface apb_event_unit_v2_if #(parameter int APB_ADDR_WIDTH = 12);
   logic [APB_ADDR_WIDTH-1:0] PADDR;
   logic [31:0]               PWDATA;
   logic                      PWRITE;
   logic                      PSEL;
   logic                      PENABLE;
   logic [31:0]               PRDATA;
   logic                      PREADY;
   logic                      PSLVERR;
   modport master (output PADDR, PWDATA, PWRITE, PSEL, PENABLE, input PRDATA, PREADY, PSLVERR);
   modport slave (input PADDR, PWDATA, PWRITE, PSEL, PENABLE, output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/apb_event_unit_v2.sv
// apb_event_unit_v2: APB irq/event controller with claim/ack and sleep gating of core fetch
module apb_event_unit_v2 #(
   parameter int APB_ADDR_WIDTH = 12,
   parameter int NUM_LINES      = 32,
   parameter bit EDGE_TRIG      = 1'b0
) (
   input  logic                 HCLK,
   input  logic                 HRESETn,
   apb_event_unit_v2_if.slave   apb,
   input  logic [NUM_LINES-1:0] irq_i,
   input  logic [NUM_LINES-1:0] event_i,
   output logic                 irq_o,
   output logic                 fetch_enable_o
);
   typedef enum logic {RUN, SLEEP} state_t;
   typedef logic [NUM_LINES-1:0] vec_t;
   state_t state_q;
   logic fetch_q;
   vec_t irq_en_q, irq_en_d, irq_pend_q, irq_pend_d, irq_ack_q, irq_ack_d;
   vec_t evt_en_q, evt_en_d, evt_pend_q, evt_pend_d, irq_prev_q, evt_prev_q;
   vec_t wdata, irq_new, evt_new, top;
   logic wr, rd, rd_ack, pend_wr, claim, wake, sleep_req, unused_addr;
   logic [3:0] off;
   logic [31:0] rdata;
   assign wr          = apb.PSEL & apb.PENABLE & apb.PWRITE;
   assign rd          = apb.PSEL & apb.PENABLE & ~apb.PWRITE;
   assign off         = apb.PADDR[5:2];
   assign wdata       = apb.PWDATA[NUM_LINES-1:0];
   assign unused_addr = ^{apb.PADDR[APB_ADDR_WIDTH-1:6], apb.PADDR[1:0]};
   assign irq_new     = (EDGE_TRIG ? irq_i & ~irq_prev_q : irq_i) & irq_en_q;
   assign evt_new     = (EDGE_TRIG ? event_i & ~evt_prev_q : event_i) & evt_en_q;
   assign rd_ack      = rd & (off == 4'h4);
   assign pend_wr     = wr & (off == 4'h1 || off == 4'h2 || off == 4'h3);
   assign claim       = ~|irq_ack_q & |irq_pend_q & ~pend_wr & ~rd_ack;
   assign wake        = |(evt_pend_q | evt_new) | |(irq_pend_q | irq_new) | |irq_ack_q;
   assign sleep_req   = wr & (off == 4'h7) & apb.PWDATA[0];
   assign irq_o          = |irq_ack_q;
   assign fetch_enable_o = fetch_q;
   assign apb.PREADY     = 1'b1;
   assign apb.PSLVERR    = 1'b0;
   assign apb.PRDATA     = rd ? rdata : '0;
   // topmost pending line has priority for the next claim
   always_comb begin
      top = '0;
      for (int i = 0; i < NUM_LINES; i++) if (irq_pend_q[i]) top = vec_t'(1) << i;
   end
   // register next-state: arrival, then set, then clear, then direct write, then claim removal
   always_comb begin
      irq_pend_d = irq_pend_q | irq_new;
      irq_pend_d = (wr && off == 4'h2) ? irq_pend_d | wdata : irq_pend_d;
      irq_pend_d = (wr && off == 4'h3) ? irq_pend_d & ~wdata : irq_pend_d;
      irq_pend_d = (wr && off == 4'h1) ? wdata : irq_pend_d;
      irq_pend_d = claim ? irq_pend_d & ~top : irq_pend_d;
      irq_ack_d  = claim ? top : rd_ack ? '0 : irq_ack_q;
      irq_en_d   = (wr && off == 4'h0) ? wdata : irq_en_q;
      evt_en_d   = (wr && off == 4'h5) ? wdata : evt_en_q;
      evt_pend_d = ((rd && off == 4'h6) ? '0 : evt_pend_q) | evt_new;
   end
   // read mux for the mapped offsets; everything else reads zero
   always_comb begin
      rdata = '0;
      case (off)
         4'h0:    rdata = 32'(irq_en_q);
         4'h1:    rdata = 32'(irq_pend_q);
         4'h4:    rdata = 32'(irq_ack_q);
         4'h5:    rdata = 32'(evt_en_q);
         4'h6:    rdata = 32'(evt_pend_q);
         4'h7:    rdata = {31'b0, state_q == SLEEP};
         default: rdata = '0;
      endcase
   end
   // register file and edge-detect history
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         irq_en_q   <= '0;
         irq_pend_q <= '0;
         irq_ack_q  <= '0;
         evt_en_q   <= '0;
         evt_pend_q <= '0;
         irq_prev_q <= '0;
         evt_prev_q <= '0;
      end else begin
         irq_en_q   <= irq_en_d;
         irq_pend_q <= irq_pend_d;
         irq_ack_q  <= irq_ack_d;
         evt_en_q   <= evt_en_d;
         evt_pend_q <= evt_pend_d;
         irq_prev_q <= irq_i;
         evt_prev_q <= event_i;
      end
   end
   // sleep FSM: sleep only when nothing could wake us, leave as soon as something does
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q <= RUN;
         fetch_q <= 1'b1;
      end else if (state_q == RUN) begin
         if (sleep_req && !wake) begin
            state_q <= SLEEP;
            fetch_q <= 1'b0;
         end
      end else if (wake) begin
         state_q <= RUN;
         fetch_q <= 1'b1;
      end
   end
endmodule

// File: tb/tb_apb_event_unit_v2.sv
// tb_apb_event_unit_v2: scoreboard bench driving a level/32-line and an edge/12-line unit in lockstep
module tb_apb_event_unit_v2;
   typedef struct packed {
      logic            chk;
      logic [1:0][31:0] rd;
      logic [1:0]      irq;
      logic [1:0]      fe;
   } exp_t;
   logic HCLK = 1'b0, HRESETn = 1'b0;
   logic psel = 1'b0, pen = 1'b0, pwr = 1'b0;
   logic [11:0] paddr = '0;
   logic [31:0] wd = '0, irq = '0, evt = '0;
   logic irq_o0, irq_o1, fe0, fe1;
   int n_tests = 0, n_fail = 0;
   exp_t sb[$];
   exp_t cur;
   logic [31:0] mask [2] = '{32'hFFFF_FFFF, 32'h0000_0FFF};
   bit          et   [2] = '{1'b0, 1'b1};
   logic [31:0] m_en[2], m_pend[2], m_ack[2], m_een[2], m_epend[2], m_ip[2], m_ep[2];
   logic [31:0] n_en[2], n_pend[2], n_ack[2], n_een[2], n_epend[2], n_ip[2], n_ep[2];
   bit          m_sleep[2], n_sleep[2];
   apb_event_unit_v2_if #(.APB_ADDR_WIDTH(12)) bus0 ();
   apb_event_unit_v2_if #(.APB_ADDR_WIDTH(12)) bus1 ();
   assign bus0.PADDR = paddr;  assign bus1.PADDR = paddr;
   assign bus0.PWDATA = wd;    assign bus1.PWDATA = wd;
   assign bus0.PWRITE = pwr;   assign bus1.PWRITE = pwr;
   assign bus0.PSEL = psel;    assign bus1.PSEL = psel;
   assign bus0.PENABLE = pen;  assign bus1.PENABLE = pen;
   apb_event_unit_v2 #(.APB_ADDR_WIDTH(12), .NUM_LINES(32), .EDGE_TRIG(1'b0)) dut0 (
      .HCLK(HCLK), .HRESETn(HRESETn), .apb(bus0), .irq_i(irq), .event_i(evt),
      .irq_o(irq_o0), .fetch_enable_o(fe0));
   apb_event_unit_v2 #(.APB_ADDR_WIDTH(12), .NUM_LINES(12), .EDGE_TRIG(1'b1)) dut1 (
      .HCLK(HCLK), .HRESETn(HRESETn), .apb(bus1), .irq_i(irq[11:0]), .event_i(evt[11:0]),
      .irq_o(irq_o1), .fetch_enable_o(fe1));
   always #5 HCLK = ~HCLK;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask
   // monitor: pops one expectation per cycle and compares away from the clock edge
   always @(negedge HCLK) begin
      if (sb.size() != 0) begin
         cur = sb.pop_front();
         chk("irq_o dut0", {31'b0, irq_o0}, {31'b0, cur.irq[0]});
         chk("irq_o dut1", {31'b0, irq_o1}, {31'b0, cur.irq[1]});
         chk("fetch_en dut0", {31'b0, fe0}, {31'b0, cur.fe[0]});
         chk("fetch_en dut1", {31'b0, fe1}, {31'b0, cur.fe[1]});
         chk("pready/pslverr", {28'b0, bus1.PREADY, bus1.PSLVERR, bus0.PREADY, bus0.PSLVERR}, 32'ha);
         if (cur.chk) begin
            chk("prdata dut0", bus0.PRDATA, cur.rd[0]);
            chk("prdata dut1", bus1.PRDATA, cur.rd[1]);
         end
      end
   end
   // reference model: pushes this cycle's expected outputs, then advances one clock
   task automatic tick();
      exp_t x;
      logic acc, w, r, rack, claim, wake, found;
      logic [3:0] o;
      logic [31:0] ii, ee, hit, ehit, inew, enew, p, top;
      acc = psel & pen;
      w = acc & pwr;
      r = acc & ~pwr;
      o = paddr[5:2];
      rack = r && o == 4'h4;
      x = '0;
      x.chk = r | ~HRESETn;
      for (int k = 0; k < 2; k++) begin
         if (!HRESETn) begin
            m_en[k] = 0; m_pend[k] = 0; m_ack[k] = 0; m_een[k] = 0;
            m_epend[k] = 0; m_ip[k] = 0; m_ep[k] = 0; m_sleep[k] = 0;
         end
         ii = irq & mask[k];
         ee = evt & mask[k];
         hit = et[k] ? ii & ~m_ip[k] : ii;
         ehit = et[k] ? ee & ~m_ep[k] : ee;
         inew = hit & m_en[k];
         enew = ehit & m_een[k];
         if (r)
            case (o)
               4'h0: x.rd[k] = m_en[k];
               4'h1: x.rd[k] = m_pend[k];
               4'h4: x.rd[k] = m_ack[k];
               4'h5: x.rd[k] = m_een[k];
               4'h6: x.rd[k] = m_epend[k];
               4'h7: x.rd[k] = {31'b0, m_sleep[k]};
               default: x.rd[k] = 0;
            endcase
         x.irq[k] = m_ack[k] != 0;
         x.fe[k] = !m_sleep[k];
         p = m_pend[k] | inew;
         if (w && o == 4'h2) p = p | (wd & mask[k]);
         if (w && o == 4'h3) p = p & ~wd;
         if (w && o == 4'h1) p = wd & mask[k];
         claim = m_ack[k] == 0 && m_pend[k] != 0 && !(w && o >= 4'h1 && o <= 4'h3) && !rack;
         top = 0;
         found = 0;
         for (int i = 31; i >= 0; i--)
            if (!found && m_pend[k][i]) begin
               top[i] = 1'b1;
               found = 1'b1;
            end
         wake = (m_epend[k] | enew) != 0 || (m_pend[k] | inew) != 0 || m_ack[k] != 0;
         n_ack[k] = claim ? top : rack ? 32'h0 : m_ack[k];
         n_pend[k] = claim ? p & ~top : p;
         n_en[k] = (w && o == 4'h0) ? wd & mask[k] : m_en[k];
         n_een[k] = (w && o == 4'h5) ? wd & mask[k] : m_een[k];
         n_epend[k] = ((r && o == 4'h6) ? 32'h0 : m_epend[k]) | enew;
         n_sleep[k] = m_sleep[k] ? !wake : (w && o == 4'h7 && wd[0] && !wake);
         n_ip[k] = ii;
         n_ep[k] = ee;
      end
      sb.push_back(x);
      @(posedge HCLK);
      if (HRESETn)
         for (int k = 0; k < 2; k++) begin
            m_en[k] = n_en[k]; m_pend[k] = n_pend[k]; m_ack[k] = n_ack[k]; m_een[k] = n_een[k];
            m_epend[k] = n_epend[k]; m_ip[k] = n_ip[k]; m_ep[k] = n_ep[k]; m_sleep[k] = n_sleep[k];
         end
      #1;
   endtask
   task automatic idle(input int n);
      psel = 0; pen = 0; pwr = 0;
      repeat (n) tick();
   endtask
   task automatic apb(input logic w, input logic [3:0] o, input logic [31:0] d);
      psel = 1; pen = 0; pwr = w; wd = d;
      paddr = {6'($urandom), o, 2'b00};
      tick();
      pen = 1;
      tick();
      psel = 0; pen = 0;
   endtask
   task automatic do_reset();
      psel = 0; pen = 0;
      HRESETn = 0;
      tick();
      HRESETn = 1;
      tick();
   endtask
   // directed scenarios followed by randomized traffic
   initial begin
      @(posedge HCLK);
      #1;
      tick();
      tick();
      HRESETn = 1;
      idle(1);
      apb(1, 4'h0, 32'h14);
      irq = 32'h14; tick(); irq = 0;
      idle(1);
      apb(0, 4'h1, 0);
      apb(0, 4'h4, 0);
      idle(3);
      apb(0, 4'h4, 0);
      idle(2);
      do_reset();
      apb(1, 4'h0, 32'h1);
      irq = 32'h2;
      idle(4);
      apb(0, 4'h1, 0);
      apb(1, 4'h0, 32'h3);
      idle(3);
      apb(0, 4'h4, 0);
      irq = 0;
      idle(2);
      do_reset();
      apb(1, 4'h0, 32'h1);
      irq = 32'h1;
      idle(10);
      apb(0, 4'h4, 0);
      idle(4);
      irq = 0; idle(2);
      irq = 32'h1; idle(3);
      apb(0, 4'h4, 0);
      irq = 0;
      idle(2);
      do_reset();
      apb(1, 4'h0, 32'h8);
      psel = 1; pen = 0; pwr = 1; paddr = 12'h00c; wd = 32'h8;
      tick();
      pen = 1; irq = 32'h8;
      tick();
      psel = 0; pen = 0; irq = 0;
      idle(2);
      apb(0, 4'h1, 0);
      apb(1, 4'h0, 0);
      apb(1, 4'h2, 32'h8000_0000);
      idle(2);
      apb(0, 4'h4, 0);
      idle(1);
      do_reset();
      apb(1, 4'h5, 32'h1);
      apb(1, 4'h7, 32'h1);
      idle(3);
      apb(0, 4'h7, 0);
      evt = 32'h1; tick(); evt = 0;
      idle(2);
      apb(0, 4'h6, 0);
      apb(0, 4'h6, 0);
      do_reset();
      apb(1, 4'h5, 32'h1);
      evt = 32'h1; tick(); evt = 0;
      apb(1, 4'h7, 32'h1);
      idle(2);
      apb(0, 4'h6, 0);
      apb(1, 4'h7, 32'h1);
      idle(2);
      HRESETn = 0;
      tick();
      tick();
      HRESETn = 1;
      idle(2);
      repeat (1500) begin
         if ($urandom_range(0, 299) == 0) do_reset();
         if ($urandom_range(0, 2) == 0)
            irq = ($urandom_range(0, 3) == 0) ? 32'h1 << $urandom_range(0, 31) : irq & $urandom;
         if ($urandom_range(0, 3) == 0)
            evt = ($urandom_range(0, 5) == 0) ? 32'h1 << $urandom_range(0, 31) : 32'h0;
         if ($urandom_range(0, 2) == 0)
            apb(1'($urandom), ($urandom_range(0, 9) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7)),
                ($urandom_range(0, 1) == 0) ? $urandom : $urandom & $urandom & $urandom);
         else
            idle(1);
      end
      irq = 0; evt = 0;
      idle(2);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
